// File: rtl/hazard_tnew_ctrl.sv
// Decode-stage Tnew/Tuse hazard controller: tracks E/M/W write records, derives
// stall, pipeline enables, D-stage forwarding selects and a saturating stall counter.
package hazard_tnew_pkg;
  localparam int NUM_OPND = 2;

  typedef enum logic [1:0] {
    RES_NW  = 2'b00,
    RES_ALU = 2'b01,
    RES_DM  = 2'b10,
    RES_PC  = 2'b11
  } res_cls_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] wa;
    logic [1:0] tnew;
  } stg_rec_t;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_E  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;
  localparam logic [1:0] FWD_W  = 2'b11;
  localparam logic [1:0] TUSE_NONE = 2'b11;
endpackage

// Per-operand check: nearest-match search E > M > W, stall and forwarding select.
module hazard_opnd_chk
  import hazard_tnew_pkg::*;
(
  input  logic       d_valid,
  input  logic [4:0] src,
  input  logic [1:0] tuse,
  input  stg_rec_t   e_rec,
  input  stg_rec_t   m_rec,
  input  stg_rec_t   w_rec,
  output logic       stall,
  output logic [1:0] fwd
);
  logic       chk, hit;
  logic [1:0] hit_tnew, hit_code;

  assign chk = d_valid && (tuse != TUSE_NONE) && (src != 5'd0);

  always_comb begin
    hit      = 1'b0;
    hit_tnew = 2'd0;
    hit_code = FWD_RF;
    if (e_rec.valid && e_rec.wa == src) begin
      hit = 1'b1; hit_tnew = e_rec.tnew; hit_code = FWD_E;
    end else if (m_rec.valid && m_rec.wa == src) begin
      hit = 1'b1; hit_tnew = m_rec.tnew; hit_code = FWD_M;
    end else if (w_rec.valid && w_rec.wa == src) begin
      hit = 1'b1; hit_tnew = w_rec.tnew; hit_code = FWD_W;
    end
  end

  assign stall = chk && hit && (hit_tnew > tuse);
  // Not-yet-ready producers read the regfile here; the E-stage forwarder fixes them up later.
  assign fwd   = (chk && hit && hit_tnew == 2'd0) ? hit_code : FWD_RF;
endmodule

module hazard_tnew_ctrl
  import hazard_tnew_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             d_valid,
  input  logic [1:0]       d_res,
  input  logic [4:0]       d_wa,
  input  logic [4:0]       d_rs,
  input  logic [4:0]       d_rt,
  input  logic [1:0]       d_tuse_rs,
  input  logic [1:0]       d_tuse_rt,
  output logic             stall,
  output logic             pc_en,
  output logic             fd_en,
  output logic             de_clr,
  output logic [1:0]       fwd_rs_d,
  output logic [1:0]       fwd_rt_d,
  output logic [CNT_W-1:0] stall_cnt
);
  stg_rec_t e_q, m_q, w_q, d_rec;

  logic [NUM_OPND-1:0][4:0] opnd_src;
  logic [NUM_OPND-1:0][1:0] opnd_tuse;
  logic [NUM_OPND-1:0][1:0] opnd_fwd;
  logic [NUM_OPND-1:0]      opnd_stall;

  function automatic stg_rec_t age(input stg_rec_t r);
    stg_rec_t o;
    o      = r;
    o.tnew = (r.tnew == 2'd0) ? 2'd0 : r.tnew - 2'd1;
    return o;
  endfunction

  always_comb begin
    d_rec.valid = d_valid && (d_res != RES_NW) && (d_wa != 5'd0);
    d_rec.wa    = d_wa;
    unique case (res_cls_e'(d_res))
      RES_ALU: d_rec.tnew = 2'd1;
      RES_DM:  d_rec.tnew = 2'd2;
      default: d_rec.tnew = 2'd0;
    endcase
  end

  assign opnd_src  = {d_rt, d_rs};
  assign opnd_tuse = {d_tuse_rt, d_tuse_rs};

  for (genvar i = 0; i < NUM_OPND; i++) begin : g_opnd
    hazard_opnd_chk u_chk (
      .d_valid (d_valid),
      .src     (opnd_src[i]),
      .tuse    (opnd_tuse[i]),
      .e_rec   (e_q),
      .m_rec   (m_q),
      .w_rec   (w_q),
      .stall   (opnd_stall[i]),
      .fwd     (opnd_fwd[i])
    );
  end

  assign stall    = |opnd_stall;
  assign pc_en    = ~stall;
  assign fd_en    = ~stall;
  assign de_clr   = stall;
  assign fwd_rs_d = opnd_fwd[0];
  assign fwd_rt_d = opnd_fwd[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q       <= '0;
      m_q       <= '0;
      w_q       <= '0;
      stall_cnt <= '0;
    end else begin
      e_q <= stall ? stg_rec_t'('0) : d_rec;
      m_q <= age(e_q);
      w_q <= age(m_q);
      if (stall && stall_cnt != {CNT_W{1'b1}})
        stall_cnt <= stall_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_tnew_ctrl.sv
// Directed bench for hazard_tnew_ctrl: load-use, ALU-branch, $0/NW, priority, reset, saturation.
module tb_hazard_tnew_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        d_valid;
  logic [1:0]  d_res;
  logic [4:0]  d_wa, d_rs, d_rt;
  logic [1:0]  d_tuse_rs, d_tuse_rt;
  logic        stall, pc_en, fd_en, de_clr;
  logic [1:0]  fwd_rs_d, fwd_rt_d;
  logic [15:0] stall_cnt;
  logic        s_stall, s_pc_en, s_fd_en, s_de_clr;
  logic [1:0]  s_fwd_rs, s_fwd_rt;
  logic [1:0]  s_cnt;

  int total = 0;
  int bad   = 0;

  localparam logic [1:0] NW = 2'b00, ALU = 2'b01, DM = 2'b10, PC = 2'b11;

  always #5 clk = ~clk;

  hazard_tnew_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .d_valid(d_valid), .d_res(d_res), .d_wa(d_wa),
    .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .stall(stall), .pc_en(pc_en), .fd_en(fd_en), .de_clr(de_clr),
    .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d), .stall_cnt(stall_cnt)
  );

  hazard_tnew_ctrl #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .d_valid(d_valid), .d_res(d_res), .d_wa(d_wa),
    .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .stall(s_stall), .pc_en(s_pc_en), .fd_en(s_fd_en), .de_clr(s_de_clr),
    .fwd_rs_d(s_fwd_rs), .fwd_rt_d(s_fwd_rt), .stall_cnt(s_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic v, input logic [1:0] res, input logic [4:0] wa,
                       input logic [4:0] rs, input logic [1:0] trs,
                       input logic [4:0] rt, input logic [1:0] trt);
    d_valid = v; d_res = res; d_wa = wa;
    d_rs = rs; d_tuse_rs = trs; d_rt = rt; d_tuse_rt = trt;
    #1;
  endtask

  task automatic idle();
    set_d(1'b0, NW, 5'd0, 5'd0, 2'd3, 5'd0, 2'd3);
  endtask

  task automatic flush();
    idle();
    repeat (3) step();
  endtask

  // lw $8 followed by beq on $8 at tuse 0: two stall cycles
  task automatic load_use();
    set_d(1'b1, DM, 5'd8, 5'd0, 2'd3, 5'd0, 2'd3);
    step();
    set_d(1'b1, NW, 5'd0, 5'd8, 2'd0, 5'd0, 2'd3);
    step();
    step();
    flush();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    repeat (2) step();
    reset = 1'b0;
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_pc_en", pc_en, 1);
    chk("rst_fd_en", fd_en, 1);
    chk("rst_de_clr", de_clr, 0);
    chk("rst_fwd", {fwd_rs_d, fwd_rt_d}, 4'b0000);
    chk("rst_cnt", stall_cnt, 0);

    // load-use, consumer in D
    set_d(1'b1, DM, 5'd8, 5'd0, 2'd3, 5'd0, 2'd3);
    chk("lw_nostall", stall, 0);
    step();
    set_d(1'b1, NW, 5'd0, 5'd8, 2'd0, 5'd0, 2'd3);
    chk("lu0_st_e", stall, 1);
    chk("lu0_pc_en", pc_en, 0);
    chk("lu0_de_clr", de_clr, 1);
    step();
    chk("lu0_st_m", stall, 1);
    chk("lu0_fwd_m", fwd_rs_d, 2'b00);
    step();
    chk("lu0_st_w", stall, 0);
    chk("lu0_fwd_w", fwd_rs_d, 2'b11);
    chk("lu0_cnt", stall_cnt, 2);
    step();
    flush();

    // load-use, consumer in E
    set_d(1'b1, DM, 5'd8, 5'd0, 2'd3, 5'd0, 2'd3);
    step();
    set_d(1'b1, ALU, 5'd9, 5'd8, 2'd1, 5'd0, 2'd3);
    chk("lu1_st", stall, 1);
    step();
    chk("lu1_st2", stall, 0);
    chk("lu1_fwd", fwd_rs_d, 2'b00);
    chk("lu1_cnt", stall_cnt, 3);
    step();
    flush();

    // ALU to branch on rt
    set_d(1'b1, ALU, 5'd5, 5'd0, 2'd3, 5'd0, 2'd3);
    step();
    set_d(1'b1, NW, 5'd0, 5'd0, 2'd3, 5'd5, 2'd0);
    chk("alu_st", stall, 1);
    chk("alu_fwd_e", fwd_rt_d, 2'b00);
    step();
    chk("alu_st2", stall, 0);
    chk("alu_fwd_m", fwd_rt_d, 2'b10);
    chk("alu_cnt", stall_cnt, 4);
    chk("sat_cnt_a", s_cnt, 3);
    step();
    flush();

    // $0 producer and consumer
    set_d(1'b1, DM, 5'd0, 5'd0, 2'd3, 5'd0, 2'd3);
    step();
    set_d(1'b1, NW, 5'd0, 5'd0, 2'd0, 5'd0, 2'd0);
    chk("zero_st", stall, 0);
    chk("zero_fwd", {fwd_rs_d, fwd_rt_d}, 4'b0000);
    flush();

    // NW-class producer to $7
    set_d(1'b1, NW, 5'd7, 5'd0, 2'd3, 5'd0, 2'd3);
    step();
    set_d(1'b1, NW, 5'd0, 5'd7, 2'd0, 5'd7, 2'd0);
    chk("nw_st", stall, 0);
    chk("nw_fwd", {fwd_rs_d, fwd_rt_d}, 4'b0000);
    flush();

    // invalid D instruction never stalls
    set_d(1'b1, DM, 5'd4, 5'd0, 2'd3, 5'd0, 2'd3);
    step();
    set_d(1'b0, NW, 5'd0, 5'd4, 2'd0, 5'd0, 2'd3);
    chk("dinv_st", stall, 0);
    flush();

    // nearest-match priority: PC writer in M, ALU writer in E, rs==rt
    set_d(1'b1, PC, 5'd3, 5'd0, 2'd3, 5'd0, 2'd3);
    step();
    set_d(1'b1, ALU, 5'd3, 5'd0, 2'd3, 5'd0, 2'd3);
    step();
    set_d(1'b1, NW, 5'd0, 5'd3, 2'd0, 5'd3, 2'd1);
    chk("pri_st", stall, 1);
    chk("pri_fwd_rs", fwd_rs_d, 2'b00);
    chk("pri_fwd_rt", fwd_rt_d, 2'b00);
    step();
    chk("pri_st2", stall, 0);
    chk("pri_fwd_rs2", fwd_rs_d, 2'b10);
    chk("pri_fwd_rt2", fwd_rt_d, 2'b10);
    chk("pri_cnt", stall_cnt, 5);
    step();
    flush();

    // reset during a load-use stall
    set_d(1'b1, DM, 5'd8, 5'd0, 2'd3, 5'd0, 2'd3);
    step();
    set_d(1'b1, NW, 5'd0, 5'd8, 2'd0, 5'd8, 2'd0);
    chk("rms_st", stall, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("rms_st2", stall, 0);
    chk("rms_cnt", stall_cnt, 0);
    chk("rms_fwd", {fwd_rs_d, fwd_rt_d}, 4'b0000);
    chk("rms_scnt", s_cnt, 0);
    flush();

    // counter saturation on the 2-bit instance
    load_use();
    chk("sat_cnt_2", s_cnt, 2);
    load_use();
    chk("sat_cnt_max", s_cnt, 3);
    chk("sat_big_cnt", stall_cnt, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
